// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the PWM DAC bank: mode/direction encodings and the
// period-counter step function used by the top level.
package pwm_dac_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  // Counter math is done at a fixed width; callers zero-extend and truncate.
  localparam int CNT_MAX_W = 32;

  typedef struct packed {
    logic [CNT_MAX_W-1:0] cnt;
    logic                 dir;
    logic                 boundary;
  } cnt_step_t;

  function automatic cnt_step_t cnt_next(input logic [CNT_MAX_W-1:0] cnt,
                                         input logic                 dir,
                                         input logic [CNT_MAX_W-1:0] act_p,
                                         input logic                 mode);
    cnt_step_t s;
    s.cnt      = '0;
    s.dir      = DIR_UP;
    s.boundary = 1'b1;
    if (act_p != '0) begin
      if (mode == MODE_EDGE) begin
        if (cnt < act_p) begin
          s.cnt      = cnt + 32'd1;
          s.boundary = 1'b0;
        end
      end else if (dir == DIR_UP && cnt < act_p) begin
        s.cnt      = cnt + 32'd1;
        s.boundary = 1'b0;
      end else if (cnt != '0) begin
        // Down-count; reaching 0 closes the period and turns back up.
        s.cnt      = cnt - 32'd1;
        s.boundary = (s.cnt == '0);
        s.dir      = s.boundary ? DIR_UP : DIR_DOWN;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/pwm_dac_channel.sv
// One PWM channel: double-buffered duty (shadow + active) and registered compare
// against the shared period counter.
module pwm_dac_channel
  import pwm_dac_pkg::*;
#(
  parameter int DUTY_W   = 8,
  parameter int PERIOD_W = 11
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [PERIOD_W-1:0] cnt,
  input  logic                boundary,
  input  logic [DUTY_W-1:0]   duty,
  input  logic                load,
  output logic                pwm,
  output logic                pending
);

  logic [DUTY_W-1:0] shadow;
  logic [DUTY_W-1:0] act_duty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shadow   <= '0;
      act_duty <= '0;
      pending  <= 1'b0;
      pwm      <= 1'b0;
    end else begin
      if (boundary) begin
        // A load on the boundary itself skips the shadow and applies now.
        if (load)         act_duty <= duty;
        else if (pending) act_duty <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= duty;
        pending <= 1'b1;
      end
      pwm <= (PERIOD_W'(act_duty) > cnt);
    end
  end

endmodule

// File: rtl/pwm_dac_bank.sv
// Multi-channel PWM DAC: one shared edge/centre-aligned period counter driving
// CHANNELS double-buffered compare channels.
module pwm_dac_bank
  import pwm_dac_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DUTY_W   = 8,
  parameter int PERIOD_W = 11
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [PERIOD_W-1:0]        period,
  input  logic                       center_aligned,
  input  logic [CHANNELS*DUTY_W-1:0] duty,
  input  logic [CHANNELS-1:0]        duty_load,
  output logic [CHANNELS-1:0]        pwm_out,
  output logic                       period_start,
  output logic [CHANNELS-1:0]        update_pending
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] act_p;
  logic                dir;
  logic                act_mode;
  logic                boundary;
  cnt_step_t           nxt;
  logic                unused_cnt_hi;

  always_comb nxt = cnt_next(CNT_MAX_W'(cnt), dir, CNT_MAX_W'(act_p), act_mode);
  assign boundary      = nxt.boundary;
  assign unused_cnt_hi = ^nxt.cnt[CNT_MAX_W-1:PERIOD_W];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt          <= '0;
      dir          <= DIR_UP;
      act_p        <= '0;
      act_mode     <= MODE_EDGE;
      period_start <= 1'b0;
    end else begin
      cnt          <= nxt.cnt[PERIOD_W-1:0];
      dir          <= nxt.dir;
      period_start <= (cnt == '0);
      if (boundary) begin
        act_p    <= period;
        act_mode <= center_aligned;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_dac_channel #(
      .DUTY_W  (DUTY_W),
      .PERIOD_W(PERIOD_W)
    ) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .cnt     (cnt),
      .boundary(boundary),
      .duty    (duty[i*DUTY_W +: DUTY_W]),
      .load    (duty_load[i]),
      .pwm     (pwm_out[i]),
      .pending (update_pending[i])
    );
  end

endmodule

// File: tb/tb_pwm_dac_bank.sv
// Directed bench for pwm_dac_bank: edge/centre modes, double buffering,
// saturated duties, period 0 and mid-period reset.
module tb_pwm_dac_bank;

  logic        clk = 1'b0;
  logic        resetn;
  logic [10:0] period;
  logic        center_aligned;
  logic [15:0] duty;
  logic [1:0]  duty_load;
  logic [1:0]  pwm_out;
  logic        period_start;
  logic [1:0]  update_pending;

  int n_chk  = 0;
  int n_fail = 0;
  int ph     = 0;  // expected counter value for the current cycle (edge mode)
  int ci     = 0;  // index into the centre-mode count table
  int cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

  pwm_dac_bank dut (
    .clk           (clk),
    .resetn        (resetn),
    .period        (period),
    .center_aligned(center_aligned),
    .duty          (duty),
    .duty_load     (duty_load),
    .pwm_out       (pwm_out),
    .period_start  (period_start),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge-mode run: output after each edge reflects the count before it.
  task automatic run(input int n, input int p, input int d0, input int d1, input string tag);
    logic [1:0] e;
    for (int k = 0; k < n; k++) begin
      e[0] = (ph < d0);
      e[1] = (ph < d1);
      step();
      chk({tag, "_pwm"}, 32'(pwm_out), 32'(e));
      chk({tag, "_ps"}, 32'(period_start), 32'(ph == 0));
      ph = (ph >= p) ? 0 : ph + 1;
    end
  endtask

  task automatic run_ctr(input int n, input int d0, input string tag);
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_pwm0"}, 32'(pwm_out[0]), 32'(cseq[ci % 8] < d0));
      chk({tag, "_ps"}, 32'(period_start), 32'(cseq[ci % 8] == 0));
      ci++;
    end
  endtask

  initial begin
    resetn = 1'b0; period = 11'd9; center_aligned = 1'b0;
    duty = {8'd0, 8'd3}; duty_load = 2'b00;
    step(); step();
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd0);
    chk("rst_pend", 32'(update_pending), 32'd0);

    // Release with loads present: first edge is a boundary.
    resetn = 1'b1; duty_load = 2'b11;
    step();
    chk("rel_pwm", 32'(pwm_out), 32'd0);
    chk("rel_ps", 32'(period_start), 32'd1);
    duty_load = 2'b00; ph = 0;
    run(20, 9, 3, 0, "edge3");

    // Mid-period load of 7 at cnt=4 waits for the boundary.
    run(4, 9, 3, 0, "pre7");
    duty = {8'd0, 8'd7}; duty_load = 2'b01;
    run(1, 9, 3, 0, "ld7");
    duty_load = 2'b00;
    chk("pend7_a", 32'(update_pending), 32'd1);
    run(4, 9, 3, 0, "hold7");
    chk("pend7_b", 32'(update_pending), 32'd1);
    run(1, 9, 3, 0, "bnd7");
    chk("pend7_c", 32'(update_pending), 32'd0);
    run(10, 9, 7, 0, "edge7");

    // Duty above period: constant high, then 0 from the next boundary.
    duty = {8'd0, 8'd255}; duty_load = 2'b01;
    run(1, 9, 7, 0, "ld255");
    duty_load = 2'b00;
    run(9, 9, 7, 0, "pre255");
    run(30, 9, 255, 0, "sat");
    run(3, 9, 255, 0, "sat2");
    duty = {8'd0, 8'd0}; duty_load = 2'b01;
    run(1, 9, 255, 0, "ld0");
    duty_load = 2'b00;
    run(6, 9, 255, 0, "sat3");
    run(10, 9, 0, 0, "zero");

    // Centre mode, period 4, duty 2; inputs take effect only at boundary.
    period = 11'd4; center_aligned = 1'b1;
    duty = {8'd0, 8'd2}; duty_load = 2'b01;
    run(1, 9, 0, 0, "ldc");
    duty_load = 2'b00;
    chk("pendc_a", 32'(update_pending), 32'd1);
    run(9, 9, 0, 0, "prec");
    chk("pendc_b", 32'(update_pending), 32'd0);
    run_ctr(16, 2, "ctr");

    // Switch to period 0 with loads landing on the centre boundary.
    period = 11'd0; center_aligned = 1'b0;
    run_ctr(7, 2, "ctr2");
    duty = {8'd9, 8'd0}; duty_load = 2'b11;
    step();
    chk("p0_bnd_pwm", 32'(pwm_out), 32'h1);
    chk("p0_bnd_ps", 32'(period_start), 32'd0);
    duty_load = 2'b00; ph = 0;
    run(5, 0, 0, 9, "p0");
    chk("p0_pend", 32'(update_pending), 32'd0);
    period = 11'd5;
    run(1, 0, 0, 9, "p0to5");
    run(12, 5, 0, 9, "p5");

    // Reset mid-period discards a pending load.
    run(4, 5, 0, 9, "prerst");
    duty = {8'd9, 8'd3}; duty_load = 2'b01;
    run(1, 5, 0, 9, "ldrst");
    duty_load = 2'b00;
    chk("rst2_pend_a", 32'(update_pending), 32'd1);
    resetn = 1'b0;
    step();
    chk("rst2_pwm", 32'(pwm_out), 32'd0);
    chk("rst2_ps", 32'(period_start), 32'd0);
    chk("rst2_pend", 32'(update_pending), 32'd0);
    duty = {8'd0, 8'd6}; duty_load = 2'b11; resetn = 1'b1;
    step();
    chk("rel2_pwm", 32'(pwm_out), 32'd0);
    chk("rel2_ps", 32'(period_start), 32'd1);
    chk("rel2_pend", 32'(update_pending), 32'd0);
    duty_load = 2'b00; ph = 0;
    run(12, 5, 6, 0, "post");
    chk("post_pend", 32'(update_pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
